// File: rtl/lsu_mem_stage.sv
// -----------------------------------------------------------------------------
// lsu_mem_stage
//   Memory-access stage between execute and a word-wide data memory (dm).
//   Takes one load/store at a time over valid/ready, turns the byte address
//   into a dm word address, performs read-modify-write for byte/half stores,
//   sign/zero-extends loads and returns exactly one response pulse per request.
//
// Parameters
//   RD_LAT      dm read latency (1..4) from dm_add stable to dm_data_out valid
//
// Ports
//   clk, rst    clock; synchronous active-high reset
//   req_*       request: valid/ready handshake, we, size (0 byte, 1 half,
//               2 word, 3 illegal), signed (loads), byte addr, right-aligned wdata
//   rsp_*       one-cycle rsp_valid pulse with rdata (0 for stores/errors) and err
//   dm_*        word address, write data, write enable, read data
// -----------------------------------------------------------------------------
module lsu_mem_stage #(
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] dm_add,
    output logic [31:0] dm_data_in,
    output logic        dm_wen,
    input  logic [31:0] dm_data_out
);

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR, RESP} state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_BAD  = 2'd3;

    state_t      state, state_n;
    logic        we_q, signed_q;
    logic [1:0]  size_q, lane_q;
    logic [2:0]  cnt;
    logic        accept, req_err, rd_done;
    logic [4:0]  shamt;
    logic [31:0] lane_word, load_val, lane_mask, merged;

    // Strobes decode directly from state so each lasts exactly one state visit.
    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign dm_wen    = (state == WR);

    assign accept  = req_valid & req_ready;
    assign req_err = (req_size == SZ_BAD)
                   | ((req_size == SZ_HALF) & req_addr[0])
                   | ((req_size == SZ_WORD) & (|req_addr[1:0]));

    // RD_WAIT spans RD_LAT+1 cycles: one for dm to see the new address, then
    // RD_LAT cycles of read latency; the read word is sampled on the last one.
    assign rd_done = (state == RD_WAIT) && (cnt == 3'(RD_LAT));

    // Lane handling on the captured address (little-endian).
    assign shamt     = {lane_q, 3'b000};
    assign lane_word = dm_data_out >> shamt;
    assign lane_mask = ((size_q == SZ_BYTE) ? 32'h0000_00FF : 32'h0000_FFFF) << shamt;
    // dm_data_in holds the right-aligned store data until the merged word replaces it.
    assign merged    = (dm_data_out & ~lane_mask) | ((dm_data_in << shamt) & lane_mask);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        load_val = dm_data_out;
        unique case (size_q)
            SZ_BYTE: load_val = {{24{signed_q & lane_word[7]}},  lane_word[7:0]};
            SZ_HALF: load_val = {{16{signed_q & lane_word[15]}}, lane_word[15:0]};
            default: load_val = dm_data_out;
        endcase
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (req_err)                             state_n = RESP;
                    else if (!req_we || req_size != SZ_WORD) state_n = RD_WAIT;
                    else                                     state_n = WR;
                end
            end
            RD_WAIT: if (rd_done) state_n = we_q ? WR : RESP;
            WR:      state_n = RESP;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
            dm_add     <= '0;
            dm_data_in <= '0;
        end else begin
            state <= state_n;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        cnt <= '0;
                        if (req_err) begin
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end else begin
                            dm_add <= {2'b00, req_addr[31:2]};
                            if (req_we) dm_data_in <= req_wdata;
                        end
                    end
                end
                RD_WAIT: begin
                    if (rd_done) begin
                        if (we_q) begin
                            dm_data_in <= merged;
                        end else begin
                            rsp_rdata <= load_val;
                            rsp_err   <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                WR: begin
                    rsp_rdata <= '0;
                    rsp_err   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // NOTE: request payload is deliberately not reset; it is only read after a handshake loads it.
    always_ff @(posedge clk) begin
        if (accept) begin
            we_q     <= req_we;
            size_q   <= req_size;
            signed_q <= req_signed;
            lane_q   <= req_addr[1:0];
        end
    end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_lsu_mem_stage
//   Two instances (RD_LAT=1 and RD_LAT=3), each with its own latency-accurate
//   dm model. Expected results come from a byte-array memory model and the
//   load/store/error rules; directed cases are followed by random traffic.
// -----------------------------------------------------------------------------
module tb_lsu_mem_stage;

    localparam int LAT0 = 1;
    localparam int LAT1 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic [1:0]       req_valid, req_ready, req_we, req_signed, rsp_valid, rsp_err, dm_wen;
    logic [1:0][1:0]  req_size;
    logic [1:0][31:0] req_addr, req_wdata, rsp_rdata, dm_add, dm_data_in, dm_data_out;

    lsu_mem_stage #(.RD_LAT(LAT0)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_size(req_size[0]), .req_signed(req_signed[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
        .rsp_err(rsp_err[0]), .dm_add(dm_add[0]), .dm_data_in(dm_data_in[0]),
        .dm_wen(dm_wen[0]), .dm_data_out(dm_data_out[0])
    );

    lsu_mem_stage #(.RD_LAT(LAT1)) u_dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_size(req_size[1]), .req_signed(req_signed[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
        .rsp_err(rsp_err[1]), .dm_add(dm_add[1]), .dm_data_in(dm_data_in[1]),
        .dm_wen(dm_wen[1]), .dm_data_out(dm_data_out[1])
    );

    // dm models: synchronous write, read data delayed by each instance's RD_LAT.
    logic [31:0] mem  [2][256];
    logic [31:0] pipe [2][4];
    int          wen_cnt [2];
    int          rsp_cnt [2];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (dm_wen[k]) begin
                mem[k][dm_add[k][7:0]] <= dm_data_in[k];
                wen_cnt[k] <= wen_cnt[k] + 1;
            end
            if (rsp_valid[k]) rsp_cnt[k] <= rsp_cnt[k] + 1;
            pipe[k][0] <= mem[k][dm_add[k][7:0]];
            for (int j = 1; j < 4; j++) pipe[k][j] <= pipe[k][j-1];
        end
    end

    assign dm_data_out[0] = pipe[0][LAT0-1];
    assign dm_data_out[1] = pipe[1][LAT1-1];

    // Reference memory: plain byte array, byte address 0..63.
    logic [7:0] ref_mem [2][64];

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic int lat_of(input int k);
        return (k == 0) ? LAT0 : LAT1;
    endfunction

    function automatic bit is_err(input logic [1:0] size, input logic [31:0] addr);
        return (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
    endfunction

    function automatic logic [31:0] ref_load(input int k, input logic [1:0] size, input bit sgn, input int a);
        logic [31:0] v;
        case (size)
            2'd0: begin
                v = 32'(ref_mem[k][a]);
                if (sgn && v >= 32'd128) v = v - 32'd256;
            end
            2'd1: begin
                v = 32'(ref_mem[k][a]) + 32'(ref_mem[k][a+1]) * 32'd256;
                if (sgn && v >= 32'd32768) v = v - 32'd65536;
            end
            default: v = {ref_mem[k][a+3], ref_mem[k][a+2], ref_mem[k][a+1], ref_mem[k][a]};
        endcase
        return v;
    endfunction

    task automatic ref_store(input int k, input logic [1:0] size, input int a, input logic [31:0] d);
        int nbytes;
        nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        for (int i = 0; i < nbytes; i++) ref_mem[k][a+i] = d[8*i +: 8];
    endtask

    task automatic drive(input int k, input bit we, input logic [1:0] size, input bit sgn,
                         input logic [31:0] addr, input logic [31:0] wdata);
        req_valid[k]  = 1'b1;
        req_we[k]     = we;
        req_size[k]   = size;
        req_signed[k] = sgn;
        req_addr[k]   = addr;
        req_wdata[k]  = wdata;
    endtask

    // Drop valid and scramble the payload so late input changes are visible.
    task automatic release_req(input int k);
        req_valid[k]  = 1'b0;
        req_we[k]     = 1'($urandom);
        req_size[k]   = 2'($urandom);
        req_signed[k] = 1'($urandom);
        req_addr[k]   = $urandom;
        req_wdata[k]  = $urandom;
    endtask

    task automatic wait_ready(input int k);
        int n = 0;
        while (!req_ready[k] && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 20) check("ready_timeout", 32'(req_ready[k]), 32'd1);
    endtask

    // One request end to end; called and returns #1 after a rising edge.
    task automatic do_req(input int k, input bit we, input logic [1:0] size, input bit sgn,
                          input logic [31:0] addr, input logic [31:0] wdata);
        bit          err;
        int          lat, exp_lat, w0;
        logic [31:0] exp_rd;
        err     = is_err(size, addr);
        exp_rd  = (we || err) ? 32'd0 : ref_load(k, size, sgn, int'(addr[5:0]));
        exp_lat = err ? 1 : !we ? lat_of(k) + 2 : (size == 2'd2) ? 2 : lat_of(k) + 3;
        w0      = wen_cnt[k];
        wait_ready(k);
        drive(k, we, size, sgn, addr, wdata);
        @(posedge clk); #1;
        release_req(k);
        check("ready_low_busy", 32'(req_ready[k]), 32'd0);
        if (!err) check("dm_add", dm_add[k], {2'b00, addr[31:2]});
        lat = 1;
        while (!rsp_valid[k] && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        check("latency", 32'(lat), 32'(exp_lat));
        check("rsp_err", 32'(rsp_err[k]), 32'(err));
        check("rsp_rdata", rsp_rdata[k], exp_rd);
        check("dm_wen_pulses", 32'(wen_cnt[k] - w0), (we && !err) ? 32'd1 : 32'd0);
        if (we && !err) ref_store(k, size, int'(addr[5:0]), wdata);
        @(posedge clk); #1;
        check("rsp_one_cycle", 32'(rsp_valid[k]), 32'd0);
    endtask

    // Back-to-back loads with req_valid held high the whole time.
    task automatic do_stream(input int k);
        logic [31:0] s_addr [4];
        logic [1:0]  s_size [4];
        bit          s_sgn  [4];
        logic [31:0] exp_q [$];
        int          acc_t [$];
        int          rsp_t [$];
        int          t, idx, viol;
        bit          acc, busy;
        s_addr = '{32'h4, 32'h6, 32'h7, 32'h10};
        s_size = '{2'd2, 2'd1, 2'd0, 2'd2};
        s_sgn  = '{1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) exp_q.push_back(ref_load(k, s_size[i], s_sgn[i], int'(s_addr[i][5:0])));
        t = 0; idx = 0; viol = 0;
        wait_ready(k);
        drive(k, 1'b0, s_size[0], s_sgn[0], s_addr[0], 32'd0);
        while (rsp_t.size() < 4 && t < 100) begin
            busy = acc_t.size() > rsp_t.size();
            if (busy && req_ready[k]) viol++;
            if (rsp_valid[k]) begin
                rsp_t.push_back(t);
                check("stream_rdata", rsp_rdata[k], exp_q.pop_front());
            end
            acc = req_valid[k] && req_ready[k];
            if (acc) acc_t.push_back(t);
            @(posedge clk); #1; t++;
            if (acc) begin
                idx++;
                if (idx < 4) drive(k, 1'b0, s_size[idx], s_sgn[idx], s_addr[idx], 32'd0);
                else         release_req(k);
            end
        end
        release_req(k);
        check("stream_rsp_count", 32'(rsp_t.size()), 32'd4);
        check("stream_ready_busy", 32'(viol), 32'd0);
        for (int i = 0; i < 4; i++) begin
            if (i < rsp_t.size() && i < acc_t.size())
                check("stream_latency", 32'(rsp_t[i] - acc_t[i]), 32'(lat_of(k) + 2));
        end
    endtask

    task automatic check_reset_values(input int k);
        check("rst_ready", 32'(req_ready[k]), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid[k]), 32'd0);
        check("rst_rsp_rdata", rsp_rdata[k], 32'd0);
        check("rst_rsp_err", 32'(rsp_err[k]), 32'd0);
        check("rst_dm_wen", 32'(dm_wen[k]), 32'd0);
        check("rst_dm_add", dm_add[k], 32'd0);
        check("rst_dm_data_in", dm_data_in[k], 32'd0);
    endtask

    initial begin
        int w0, r0, n;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) release_req(k);
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) check_reset_values(k);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int k = 0; k < 2; k++) begin
            // Known contents for bytes 0..63 through the DUT itself.
            for (int w = 0; w < 16; w++) do_req(k, 1'b1, 2'd2, 1'b0, 32'(w * 4), $urandom);

            // Word store then load at 0x8.
            do_req(k, 1'b1, 2'd2, 1'b0, 32'h8, 32'hDEADBEEF);
            do_req(k, 1'b0, 2'd2, 1'b0, 32'h8, 32'h0);
            check("t1_value", rsp_rdata[k], 32'hDEADBEEF);

            // Byte merge into a word.
            do_req(k, 1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344);
            do_req(k, 1'b1, 2'd0, 1'b0, 32'h11, 32'hFFFF_FFAA);
            do_req(k, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
            check("t2_value", rsp_rdata[k], 32'h1122AA44);

            // Load extraction and extension.
            do_req(k, 1'b1, 2'd2, 1'b0, 32'h4, 32'h80FF7F01);
            do_req(k, 1'b0, 2'd0, 1'b1, 32'h6, 32'h0);
            check("t3_sbyte6", rsp_rdata[k], 32'hFFFFFFFF);
            do_req(k, 1'b0, 2'd0, 1'b0, 32'h7, 32'h0);
            check("t3_ubyte7", rsp_rdata[k], 32'h00000080);
            do_req(k, 1'b0, 2'd1, 1'b1, 32'h4, 32'h0);
            check("t3_shalf4", rsp_rdata[k], 32'h00007F01);
            do_req(k, 1'b0, 2'd1, 1'b1, 32'h6, 32'h0);
            check("t3_shalf6", rsp_rdata[k], 32'hFFFF80FF);

            // Errors: no dm write, memory unchanged.
            w0 = wen_cnt[k];
            do_req(k, 1'b0, 2'd1, 1'b0, 32'h3, 32'h0);
            do_req(k, 1'b1, 2'd2, 1'b0, 32'h2, 32'hCAFEF00D);
            do_req(k, 1'b1, 2'd3, 1'b0, 32'h0, 32'h12345678);
            check("t4_no_wen", 32'(wen_cnt[k] - w0), 32'd0);
            do_req(k, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0);

            // Back-to-back loads.
            do_stream(k);

            // Random traffic.
            for (int i = 0; i < 60; i++)
                do_req(k, 1'($urandom), 2'($urandom), 1'($urandom), 32'($urandom_range(0, 63)), $urandom);
        end

        // Reset while a byte store is in WR.
        wait_ready(0);
        drive(0, 1'b1, 2'd0, 1'b0, 32'h21, 32'h0000005A);
        @(posedge clk); #1;
        release_req(0);
        n = 0;
        while (!dm_wen[0] && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check("t6_reached_wr", 32'(dm_wen[0]), 32'd1);
        r0  = rsp_cnt[0];
        rst = 1'b1;
        @(posedge clk); #1;
        check("t6_wen_after_rst", 32'(dm_wen[0]), 32'd0);
        check("t6_no_rsp_in_rst", 32'(rsp_valid[0]), 32'd0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("t6_no_rsp", 32'(rsp_cnt[0] - r0), 32'd0);
        check_reset_values(0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
